// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory game: state encoding and move validity check.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    ESPERA      = 4'd2,
    REGISTRA    = 4'd3,
    COMPARA     = 4'd4,
    ESCREVE     = 4'd5,
    FIM_GANHOU  = 4'd6,
    FIM_PERDEU  = 4'd7,
    FIM_TIMEOUT = 4'd8
  } estado_t;

  // A legal move has exactly one button pressed; callers zero-extend to 32 bits.
  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/jogo_desafio_param_if.sv
// Board-side bundle of the memory game: button/start inputs, LED and status/debug outputs.
interface jogo_desafio_param_if #(
  parameter int N_BOTOES = 4,
  parameter int DEPTH    = 16
);
  // No valid/ready handshake: iniciar and botoes are levels sampled every clock,
  // a move is the zero-to-nonzero transition of botoes, outputs are Moore levels.
  logic                       iniciar;
  logic [N_BOTOES-1:0]        botoes;
  logic [N_BOTOES-1:0]        leds;
  logic                       pronto;
  logic                       ganhou;
  logic                       perdeu;
  logic                       db_timeout;
  logic [3:0]                 db_estado;
  logic [$clog2(DEPTH)-1:0]   db_rodada;
  logic [$clog2(DEPTH)-1:0]   db_endereco;

  modport master (
    output iniciar, botoes,
    input  leds, pronto, ganhou, perdeu, db_timeout, db_estado, db_rodada, db_endereco
  );

  modport slave (
    input  iniciar, botoes,
    output leds, pronto, ganhou, perdeu, db_timeout, db_estado, db_rodada, db_endereco
  );
endinterface

// File: rtl/jogo_desafio_param_detector_jogada.sv
// detector_jogada: one-cycle pulse in the cycle after botoes goes from all-zero to non-zero.
module detector_jogada #(
  parameter int N_BOTOES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                tem_jogada
);
  logic algum;
  logic algum_q;

  assign algum = |botoes;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      algum_q    <= 1'b0;
      tem_jogada <= 1'b0;
    end else begin
      algum_q    <= algum;
      tem_jogada <= algum & ~algum_q;
    end
  end
endmodule

// File: rtl/jogo_desafio_param.sv
// Memory game control+datapath with sequence memory, insert phase and per-move timeout.
// Optional LED echo of the last move is enabled by defining EXIBE_JOGADA_EN.
module jogo_desafio_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic                 clock,
  input  logic                 reset,
  jogo_desafio_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CICLOS);

  logic                tem_jogada;
  estado_t             estado, nxt;
  logic [AW-1:0]       rodada, endereco;
  logic [CW-1:0]       cnt;
  logic [N_BOTOES-1:0] jogada, jogada_nxt, leds_q, leds_nxt;
  logic [N_BOTOES-1:0] mem [DEPTH];
  logic                pronto_q, ganhou_q, perdeu_q, timeout_q;
  logic                repete, acerto;

  detector_jogada #(.N_BOTOES(N_BOTOES)) u_detector (
    .clock      (clock),
    .reset      (reset),
    .botoes     (bus.botoes),
    .tem_jogada (tem_jogada)
  );

  assign repete     = endereco < rodada;
  assign acerto     = (jogada == mem[endereco]) && eh_one_hot(32'(jogada));
  assign jogada_nxt = (estado == REGISTRA) ? bus.botoes : jogada;

  always_comb begin
    nxt = estado;
    case (estado)
      INICIAL:  if (bus.iniciar) nxt = PREPARA;
      PREPARA:  nxt = ESPERA;
      // A move arriving together with the timeout condition takes priority.
      ESPERA: begin
        if (tem_jogada)                              nxt = REGISTRA;
        else if (cnt == CW'(TIMEOUT_CICLOS - 1))     nxt = FIM_TIMEOUT;
      end
      REGISTRA: nxt = COMPARA;
      COMPARA: begin
        if (repete) nxt = acerto ? ESPERA : FIM_PERDEU;
        else        nxt = eh_one_hot(32'(jogada)) ? ESCREVE : FIM_PERDEU;
      end
      ESCREVE:  nxt = (rodada == AW'(DEPTH - 1)) ? FIM_GANHOU : ESPERA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (bus.iniciar) nxt = PREPARA;
      default:  nxt = INICIAL;
    endcase
  end

`ifdef EXIBE_JOGADA_EN
  logic jogou, jogou_nxt;

  always_comb begin
    jogou_nxt = jogou;
    if (estado == PREPARA)       jogou_nxt = 1'b0;
    else if (estado == REGISTRA) jogou_nxt = 1'b1;
    leds_nxt = '0;
    if ((nxt inside {REGISTRA, COMPARA, ESCREVE}) || (nxt == ESPERA && jogou_nxt))
      leds_nxt = jogada_nxt;
    else if (nxt == FIM_GANHOU)
      leds_nxt = '1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) jogou <= 1'b0;
    else        jogou <= jogou_nxt;
  end
`else
  assign leds_nxt = '0;
`endif

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      rodada    <= '0;
      endereco  <= '0;
      cnt       <= '0;
      jogada    <= '0;
      leds_q    <= '0;
      pronto_q  <= 1'b0;
      ganhou_q  <= 1'b0;
      perdeu_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado    <= nxt;
      jogada    <= jogada_nxt;
      leds_q    <= leds_nxt;
      pronto_q  <= nxt inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
      ganhou_q  <= nxt == FIM_GANHOU;
      perdeu_q  <= nxt inside {FIM_PERDEU, FIM_TIMEOUT};
      timeout_q <= nxt == FIM_TIMEOUT;
      if (estado != ESPERA)                       cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CICLOS - 1))    cnt <= cnt + CW'(1);
      case (estado)
        PREPARA: begin
          rodada   <= '0;
          endereco <= '0;
        end
        COMPARA: if (repete && acerto) endereco <= endereco + AW'(1);
        ESCREVE: begin
          if (rodada != AW'(DEPTH - 1)) begin
            rodada   <= rodada + AW'(1);
            endereco <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence memory is deliberately not reset; it is rewritten before being read.
  always_ff @(posedge clock) begin
    if (estado == ESCREVE) mem[endereco] <= jogada;
  end

  assign bus.leds        = leds_q;
  assign bus.pronto      = pronto_q;
  assign bus.ganhou      = ganhou_q;
  assign bus.perdeu      = perdeu_q;
  assign bus.db_timeout  = timeout_q;
  assign bus.db_estado   = estado;
  assign bus.db_rodada   = rodada;
  assign bus.db_endereco = endereco;
endmodule

// File: tb/tb_jogo_desafio_param.sv
// Self-checking bench for jogo_desafio_param (DEPTH=4, TIMEOUT_CICLOS=20) against a game-level model.
module tb_jogo_desafio_param;
  localparam int NB = 4;
  localparam int DP = 4;
  localparam int TO = 20;
  localparam logic [3:0] S_INI = 4'd0, S_PREP = 4'd1, S_ESP = 4'd2, S_REG = 4'd3,
                         S_GAN = 4'd6, S_PER = 4'd7, S_TMO = 4'd8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  jogo_desafio_param_if #(.N_BOTOES(NB), .DEPTH(DP)) bus ();

  jogo_desafio_param #(.N_BOTOES(NB), .DEPTH(DP), .TIMEOUT_CICLOS(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Game-level model: stored sequence, round, position in round, outcome (0 playing, 1 won, 2 lost)
  logic [NB-1:0] m_seq [DP];
  int m_rodada, m_pos, m_fim;

  function automatic logic [NB-1:0] rand_one_hot();
    return NB'(1) << $urandom_range(0, NB - 1);
  endfunction

  task automatic start_game();
    @(negedge clock); bus.iniciar = 1'b1;
    @(posedge clock); #1;
    n_tests++;
    if (bus.db_estado !== S_PREP) begin n_fail++; $display("FAIL start_prepara estado=%0d exp=%0d", bus.db_estado, S_PREP); end
    @(negedge clock); bus.iniciar = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.db_rodada, bus.db_endereco} !== {S_ESP, 2'd0, 2'd0}) begin
      n_fail++; $display("FAIL start_espera estado=%0d rodada=%0d end=%0d exp=2/0/0", bus.db_estado, bus.db_rodada, bus.db_endereco);
    end
    m_rodada = 0; m_pos = 0; m_fim = 0;
  endtask

  // One complete move: press, hold through capture, release, then compare against the model.
  task automatic press(input logic [NB-1:0] v);
    logic [3:0] exp_e, exp_f;
    logic [NB-1:0] exp_l;
    @(negedge clock); bus.botoes = v;
    repeat (4) @(posedge clock);
    @(negedge clock); bus.botoes = '0;
    @(posedge clock); #1;
    if (m_pos < m_rodada) begin
      if (v == m_seq[m_pos]) m_pos++; else m_fim = 2;
    end else if ($countones(v) == 1) begin
      m_seq[m_rodada] = v;
      if (m_rodada == DP - 1) m_fim = 1;
      else begin m_rodada++; m_pos = 0; end
    end else m_fim = 2;
    exp_e = (m_fim == 1) ? S_GAN : (m_fim == 2) ? S_PER : S_ESP;
    exp_f = (m_fim == 1) ? 4'b1100 : (m_fim == 2) ? 4'b1010 : 4'b0000;
`ifdef EXIBE_JOGADA_EN
    exp_l = (m_fim == 1) ? '1 : (m_fim == 2) ? '0 : v;
`else
    exp_l = '0;
`endif
    n_tests++;
    if (bus.db_estado !== exp_e) begin n_fail++; $display("FAIL press_estado v=%b got=%0d exp=%0d", v, bus.db_estado, exp_e); end
    n_tests++;
    if ({bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout} !== exp_f) begin
      n_fail++; $display("FAIL press_flags v=%b got=%b exp=%b", v, {bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout}, exp_f);
    end
    n_tests++;
    if ({bus.db_rodada, bus.db_endereco} !== {2'(m_rodada), 2'(m_pos)}) begin
      n_fail++; $display("FAIL press_contadores v=%b got=%0d/%0d exp=%0d/%0d", v, bus.db_rodada, bus.db_endereco, m_rodada, m_pos);
    end
    n_tests++;
    if (bus.leds !== exp_l) begin n_fail++; $display("FAIL press_leds got=%b exp=%b", bus.leds, exp_l); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.db_rodada, bus.db_endereco, bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs estado=%0d leds=%b pronto=%b exp=all zero", bus.db_estado, bus.leds, bus.pronto);
    end
    @(negedge clock); reset = 1'b1;
    repeat (3) @(posedge clock); #1;
    n_tests++;
    if (bus.db_estado !== S_INI) begin n_fail++; $display("FAIL reset_idle estado=%0d exp=0", bus.db_estado); end
  endtask

  task automatic test_win();
    logic [NB-1:0] ins [DP];
    ins[0] = 4'b0001; ins[1] = 4'b0010; ins[2] = 4'b0100; ins[3] = 4'b1000;
    start_game();
    for (int r = 0; r < DP; r++) begin
      for (int p = 0; p < r; p++) press(m_seq[p]);
      press(ins[r]);
    end
    n_tests++;
    if ({bus.ganhou, bus.pronto, bus.perdeu} !== 3'b110) begin
      n_fail++; $display("FIM_GANHOU check FAIL win_final got=%b exp=110", {bus.ganhou, bus.pronto, bus.perdeu});
    end
  endtask

  task automatic test_bad_insert();
    start_game();
    press(4'b0011);
    n_tests++;
    if (dut.mem[0] !== 4'b0001) begin n_fail++; $display("FAIL bad_insert_mem got=%b exp=0001", dut.mem[0]); end
  endtask

  task automatic test_wrong_repeat();
    start_game();
    press(4'b0001); press(4'b0001); press(4'b0010); press(4'b0001);
    @(negedge clock); bus.botoes = 4'b0100;
    repeat (3) @(posedge clock); #1;
    n_tests++;
    if (bus.perdeu !== 1'b0) begin n_fail++; $display("FAIL wrong_early perdeu=%b exp=0", bus.perdeu); end
    @(posedge clock); #1;
    n_tests++;
    if ({bus.perdeu, bus.db_estado, bus.db_endereco, bus.db_rodada} !== {1'b1, S_PER, 2'd1, 2'd2}) begin
      n_fail++; $display("FAIL wrong_latency perdeu=%b estado=%0d end=%0d rodada=%0d exp=1/7/1/2", bus.perdeu, bus.db_estado, bus.db_endereco, bus.db_rodada);
    end
    @(negedge clock); bus.botoes = '0;
  endtask

  task automatic test_timeout();
    start_game();
    repeat (19) @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.perdeu} !== {S_ESP, 1'b0}) begin n_fail++; $display("FAIL timeout_early estado=%0d perdeu=%b exp=2/0", bus.db_estado, bus.perdeu); end
    @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.db_timeout, bus.perdeu, bus.pronto, bus.ganhou} !== {S_TMO, 4'b1110}) begin
      n_fail++; $display("FAIL timeout_fire estado=%0d flags=%b exp=8/1110", bus.db_estado, {bus.db_timeout, bus.perdeu, bus.pronto, bus.ganhou});
    end
    // Pulse lands in the last allowed cycle: the move wins over the timeout.
    start_game();
    repeat (18) @(posedge clock);
    @(negedge clock); bus.botoes = 4'b0100;
    repeat (2) @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.db_timeout} !== {S_REG, 1'b0}) begin n_fail++; $display("FAIL timeout_race estado=%0d tmo=%b exp=3/0", bus.db_estado, bus.db_timeout); end
    repeat (2) @(posedge clock);
    @(negedge clock); bus.botoes = '0;
    repeat (30) @(posedge clock); #1;
    n_tests++;
    if ({bus.db_estado, bus.db_rodada} !== {S_TMO, 2'd1}) begin n_fail++; $display("FAIL timeout_after_move estado=%0d rodada=%0d exp=8/1", bus.db_estado, bus.db_rodada); end
  endtask

  task automatic test_hold();
    int n_reg = 0;
    start_game();
    @(negedge clock); bus.botoes = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (bus.db_estado == S_REG) n_reg++;
    end
    @(negedge clock); bus.botoes = '0;
    n_tests++;
    if (n_reg !== 1) begin n_fail++; $display("FAIL hold_single_pulse registra=%0d exp=1", n_reg); end
    n_tests++;
    if ({bus.db_estado, bus.db_rodada} !== {S_TMO, 2'd1}) begin n_fail++; $display("FAIL hold_end estado=%0d rodada=%0d exp=8/1", bus.db_estado, bus.db_rodada); end
  endtask

  task automatic test_reset_mid_game();
    start_game();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < r; p++) press(m_seq[p]);
      press(rand_one_hot());
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.db_estado, bus.db_rodada, bus.db_endereco, bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_async estado=%0d rodada=%0d exp=all zero", bus.db_estado, bus.db_rodada);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    repeat (3) @(posedge clock); #1;
    n_tests++;
    if (bus.db_estado !== S_INI) begin n_fail++; $display("FAIL reset_release estado=%0d exp=0", bus.db_estado); end
  endtask

  task automatic test_random();
    logic [NB-1:0] v;
    for (int g = 0; g < 6; g++) begin
      start_game();
      while (m_fim == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clock);
        if (m_pos < m_rodada) v = m_seq[m_pos]; else v = rand_one_hot();
        if ($urandom_range(0, 11) == 0) begin
          if (m_pos < m_rodada) begin
            do v = NB'($urandom_range(1, 15)); while (v == m_seq[m_pos]);
          end else begin
            do v = NB'($urandom_range(1, 15)); while ($countones(v) == 1);
          end
        end
        press(v);
      end
    end
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.botoes  = '0;
    test_reset();
    test_win();
    test_bad_insert();
    test_wrong_repeat();
    test_timeout();
    test_hold();
    test_reset_mid_game();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
